huffman_bit_packer: RTL and testbench

//  Packs variable-length entropy codes (Huffman code + appended amplitude bits) MSB-first into a byte stream.

---
 rtl/huffman_bit_packer.sv | 131 +++++++++++++
 tb/tb_huffman_bit_packer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_bit_packer.sv
// Packs right-aligned variable-length codes MSB-first into a byte stream.
// Leaves a one-cycle gap after every 0xFF byte so a downstream stuffer can
// insert its 0x00, and pads the last partial byte with 1s on flush.
module huffman_bit_packer #(
  parameter int MAX_CODE_LEN = 27,
  parameter int LEN_W        = $clog2(MAX_CODE_LEN + 1),
  parameter int ACC_W        = MAX_CODE_LEN + 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_wait,
  input  logic [MAX_CODE_LEN-1:0] i_code,
  input  logic [LEN_W-1:0]        i_len,
  input  logic                    i_valid,
  input  logic                    i_flush,
  output logic                    o_ready,
  output logic [7:0]              o_data,
  output logic                    o_valid,
  output logic                    o_data_end
);

  localparam int CNT_W = $clog2(ACC_W + 1);

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_END} state_t;

  state_t             state_q, state_nx;
  logic [ACC_W-1:0]   acc_q, acc_nx, acc_sh;
  logic [CNT_W-1:0]   cnt_q, cnt_nx, cnt_sh;
  logic               bubble_q, bubble_nx;
  logic [7:0]         data_nx, top_byte, pad_b;
  logic               valid_nx, end_nx;
  logic               emit_full, accept;

  // Place the low len bits of code directly below the fill bits already
  // held at the MSB end of the accumulator.
  function automatic logic [ACC_W-1:0] align_code(input logic [MAX_CODE_LEN-1:0] code,
                                                  input logic [LEN_W-1:0]        len,
                                                  input logic [CNT_W-1:0]        fill);
    logic [ACC_W-1:0] mask;
    logic [ACC_W-1:0] ext;
    logic [CNT_W-1:0] sh;
    mask = (ACC_W'(1) << len) - ACC_W'(1);
    ext  = ACC_W'(code) & mask;
    sh   = CNT_W'(ACC_W) - fill - CNT_W'(len);
    return ext << sh;
  endfunction

  // Fill the unused low bits of a final partial byte with 1s.
  function automatic logic [7:0] pad_byte(input logic [7:0] top, input logic [2:0] nbits);
    return top | (8'hFF >> nbits);
  endfunction

  assign top_byte  = acc_q[ACC_W-1 -: 8];
  assign emit_full = (cnt_q >= CNT_W'(8));
  assign o_ready   = !i_wait && (state_q == ST_RUN) && !bubble_q && (cnt_q < CNT_W'(16));
  assign accept    = i_valid && o_ready;

  // Next-state, emit and append decisions for one unstalled cycle.
  always_comb begin
    state_nx  = state_q;
    acc_nx    = acc_q;
    cnt_nx    = cnt_q;
    data_nx   = o_data;
    valid_nx  = 1'b0;
    end_nx    = 1'b0;
    bubble_nx = 1'b0;
    pad_b     = pad_byte(top_byte, cnt_q[2:0]);
    acc_sh    = emit_full ? (acc_q << 8) : acc_q;
    cnt_sh    = emit_full ? (cnt_q - CNT_W'(8)) : cnt_q;
    if (!bubble_q) begin
      unique case (state_q)
        ST_RUN: begin
          if (emit_full) begin
            data_nx   = top_byte;
            valid_nx  = 1'b1;
            bubble_nx = (top_byte == 8'hFF);
          end
          acc_nx = acc_sh;
          cnt_nx = cnt_sh;
          if (accept) begin
            acc_nx = acc_sh | align_code(i_code, i_len, cnt_sh);
            cnt_nx = cnt_sh + CNT_W'(i_len);
            if (i_flush) state_nx = ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (emit_full) begin
            data_nx   = top_byte;
            valid_nx  = 1'b1;
            bubble_nx = (top_byte == 8'hFF);
            acc_nx    = acc_sh;
            cnt_nx    = cnt_sh;
          end else if (cnt_q != '0) begin
            data_nx   = pad_b;
            valid_nx  = 1'b1;
            bubble_nx = (pad_b == 8'hFF);
            acc_nx    = '0;
            cnt_nx    = '0;
          end else begin
            state_nx = ST_END;
            end_nx   = 1'b1;
          end
        end
        ST_END:  state_nx = ST_RUN;
        default: state_nx = ST_RUN;
      endcase
    end
  end

  // State and output registers; i_wait freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      acc_q      <= '0;
      cnt_q      <= '0;
      bubble_q   <= 1'b0;
      o_data     <= 8'h00;
      o_valid    <= 1'b0;
      o_data_end <= 1'b0;
    end else if (!i_wait) begin
      state_q    <= state_nx;
      acc_q      <= acc_nx;
      cnt_q      <= cnt_nx;
      bubble_q   <= bubble_nx;
      o_data     <= data_nx;
      o_valid    <= valid_nx;
      o_data_end <= end_nx;
    end
  end

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Directed bench for huffman_bit_packer: packing, 0xFF gaps, flush/pad,
// back-pressure, global stall and asynchronous reset.
module tb_huffman_bit_packer;

  logic        clk = 1'b0;
  logic        rst, i_wait, i_valid, i_flush;
  logic [26:0] i_code;
  logic [4:0]  i_len;
  logic        o_ready, o_valid, o_data_end;
  logic [7:0]  o_data;

  int tests = 0;
  int fails = 0;

  logic [7:0] outq[$];
  logic [7:0] expq[$];
  bit         mbits[$];
  int         end_cnt = 0;
  bit         end_bad = 1'b0;
  bit         ff_adj  = 1'b0;
  bit         prev_ff = 1'b0;

  huffman_bit_packer dut (
    .clk(clk), .rst(rst), .i_wait(i_wait), .i_code(i_code), .i_len(i_len),
    .i_valid(i_valid), .i_flush(i_flush), .o_ready(o_ready), .o_data(o_data),
    .o_valid(o_valid), .o_data_end(o_data_end)
  );

  always #5 clk = ~clk;

  // Record every byte / end pulse the downstream would consume.
  always @(negedge clk) begin
    if (rst) begin
      prev_ff <= 1'b0;
    end else if (!i_wait) begin
      if (o_valid) outq.push_back(o_data);
      if (o_valid && o_data == 8'hFF && prev_ff) ff_adj <= 1'b1;
      prev_ff <= o_valid && (o_data == 8'hFF);
      if (o_data_end) begin
        end_cnt <= end_cnt + 1;
        if (o_valid) end_bad <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (i_valid) assert (i_len <= 5'd27) else $error("illegal i_len %0d", i_len);
  end

  // Present one code and hold it until accepted; also feeds the bit model.
  task automatic send(input logic [26:0] code, input int len, input bit fl, output int waits);
    for (int i = len - 1; i >= 0; i--) mbits.push_back(code[i]);
    i_code = code; i_len = len[4:0]; i_flush = fl; i_valid = 1'b1; waits = 0;
    @(negedge clk);
    while (!o_ready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    tests++;
    if (!o_ready) begin
      fails++;
      $display("FAIL send_accept: o_ready=%0b after %0d cycles, required 1", o_ready, waits);
    end
    @(posedge clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
  endtask

  // Turn the model bit queue into bytes, padding the tail with 1s.
  task automatic model_bytes();
    logic [7:0] b;
    expq.delete();
    while (mbits.size() > 0) begin
      b = 8'hFF;
      for (int k = 0; k < 8; k++) if (mbits.size() > 0) b[7-k] = mbits.pop_front();
      expq.push_back(b);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk); #1;
    tests++; if (o_data !== 8'h00) begin fails++; $display("FAIL rst_data: got %h want 00", o_data); end
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", o_valid); end
    tests++; if (o_data_end !== 1'b0) begin fails++; $display("FAIL rst_end: got %b want 0", o_data_end); end
    tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", o_ready); end
  endtask

  task automatic test_pack();
    int w;
    mbits.delete();
    send(27'h5, 3, 1'b0, w);
    send(27'h1F, 5, 1'b0, w);
    @(negedge clk);
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL pack_early: o_valid %b want 0", o_valid); end
    @(negedge clk);
    tests++; if (o_valid !== 1'b1 || o_data !== 8'hBF) begin
      fails++; $display("FAIL pack_byte: got v=%b d=%h want v=1 d=BF", o_valid, o_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ff_bubble();
    int w;
    mbits.delete();
    send(27'hFF, 8, 1'b0, w);
    send(27'hFF, 8, 1'b0, w);
    @(negedge clk);
    tests++; if ({o_valid, o_data, o_ready} !== {1'b1, 8'hFF, 1'b0}) begin
      fails++; $display("FAIL ff_first: got v=%b d=%h r=%b want v=1 d=FF r=0", o_valid, o_data, o_ready);
    end
    @(negedge clk);
    tests++; if ({o_valid, o_ready} !== 2'b01) begin
      fails++; $display("FAIL ff_bubble1: got v=%b r=%b want v=0 r=1", o_valid, o_ready);
    end
    @(negedge clk);
    tests++; if ({o_valid, o_data, o_ready} !== {1'b1, 8'hFF, 1'b0}) begin
      fails++; $display("FAIL ff_second: got v=%b d=%h r=%b want v=1 d=FF r=0", o_valid, o_data, o_ready);
    end
    @(negedge clk);
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL ff_bubble2: got v=%b want 0", o_valid); end
    tests++; if (ff_adj !== 1'b0) begin fails++; $display("FAIL ff_adjacent: got %b want 0", ff_adj); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    int w;
    mbits.delete();
    send(27'h2, 3, 1'b1, w);
    @(negedge clk);
    tests++; if ({o_valid, o_ready} !== 2'b00) begin
      fails++; $display("FAIL flush_wait: got v=%b r=%b want 0 0", o_valid, o_ready);
    end
    @(negedge clk);
    tests++; if ({o_valid, o_data, o_data_end} !== {1'b1, 8'h5F, 1'b0}) begin
      fails++; $display("FAIL flush_pad: got v=%b d=%h e=%b want v=1 d=5F e=0", o_valid, o_data, o_data_end);
    end
    @(negedge clk);
    tests++; if ({o_data_end, o_valid, o_ready} !== 3'b100) begin
      fails++; $display("FAIL flush_end: got e=%b v=%b r=%b want 1 0 0", o_data_end, o_valid, o_ready);
    end
    @(negedge clk);
    tests++; if ({o_data_end, o_ready} !== 2'b01) begin
      fails++; $display("FAIL flush_after: got e=%b r=%b want 0 1", o_data_end, o_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush_empty();
    int w;
    mbits.delete();
    send(27'h7FFFFFF, 0, 1'b1, w);
    @(negedge clk);
    tests++; if ({o_valid, o_data_end, o_data} !== {1'b0, 1'b0, 8'h5F}) begin
      fails++; $display("FAIL empty_flush: got v=%b e=%b d=%h want 0 0 5F", o_valid, o_data_end, o_data);
    end
    @(negedge clk);
    tests++; if ({o_data_end, o_valid} !== 2'b10) begin
      fails++; $display("FAIL empty_end: got e=%b v=%b want 1 0", o_data_end, o_valid);
    end
    @(negedge clk);
    tests++; if ({o_data_end, o_ready} !== 2'b01) begin
      fails++; $display("FAIL empty_after: got e=%b r=%b want 0 1", o_data_end, o_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int w, maxw, base, e0, cyc;
    base = outq.size(); e0 = end_cnt; maxw = 0;
    mbits.delete();
    for (int i = 0; i < 4; i++) begin
      send(27'h5A5A5A5, 27, 1'b0, w);
      if (w > maxw) maxw = w;
    end
    send(27'h7FFFFFF, 0, 1'b0, w);
    send(27'h7FFFFF3, 2, 1'b0, w);
    send(27'h5A5A5A5, 27, 1'b1, w);
    tests++; if (maxw == 0) begin fails++; $display("FAIL b2b_backpressure: waits=%0d want >0", maxw); end
    cyc = 0;
    while (end_cnt == e0 && cyc < 300) begin @(posedge clk); cyc++; end
    #1;
    tests++; if (end_cnt == e0) begin fails++; $display("FAIL b2b_end: no end pulse after %0d cycles", cyc); end
    model_bytes();
    tests++; if (outq.size() - base != expq.size()) begin
      fails++; $display("FAIL b2b_count: got %0d bytes want %0d", outq.size() - base, expq.size());
    end else begin
      for (int i = 0; i < expq.size(); i++) begin
        tests++; if (outq[base+i] !== expq[i]) begin
          fails++; $display("FAIL b2b_byte%0d: got %h want %h", i, outq[base+i], expq[i]);
        end
      end
      tests++; if (outq[base] !== 8'hB4) begin fails++; $display("FAIL b2b_first: got %h want B4", outq[base]); end
    end
    tests++; if (end_bad !== 1'b0 || ff_adj !== 1'b0) begin
      fails++; $display("FAIL b2b_flags: end_with_valid=%b ff_adjacent=%b want 0 0", end_bad, ff_adj);
    end
  endtask

  task automatic test_wait();
    int w, base, e0, cyc;
    logic [9:0] snap;
    base = outq.size(); e0 = end_cnt;
    mbits.delete();
    for (int p = 0; p < 2; p++) begin
      if (p == 0) begin
        send(27'h5A5A5A5, 27, 1'b0, w);
        send(27'h5A5A5A5, 27, 1'b0, w);
      end else begin
        send(27'h5A5A5A5, 27, 1'b0, w);
        send(27'h5A5A5A5, 27, 1'b0, w);
        send(27'h7FFFFFF, 0, 1'b0, w);
        send(27'h7FFFFF3, 2, 1'b0, w);
        send(27'h5A5A5A5, 27, 1'b1, w);
      end
      i_wait = 1'b1;
      @(negedge clk);
      snap = {o_data, o_valid, o_data_end};
      tests++; if (o_ready !== 1'b0) begin fails++; $display("FAIL wait_ready%0d: got %b want 0", p, o_ready); end
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        tests++; if ({o_data, o_valid, o_data_end} !== snap || o_ready !== 1'b0) begin
          fails++; $display("FAIL wait_frozen%0d_%0d: got %h want %h r=%b", p, c,
                            {o_data, o_valid, o_data_end}, snap, o_ready);
        end
      end
      @(posedge clk); #1;
      i_wait = 1'b0;
    end
    cyc = 0;
    while (end_cnt == e0 && cyc < 300) begin @(posedge clk); cyc++; end
    #1;
    tests++; if (end_cnt == e0) begin fails++; $display("FAIL wait_end: no end pulse after %0d cycles", cyc); end
    model_bytes();
    tests++; if (outq.size() - base != expq.size()) begin
      fails++; $display("FAIL wait_count: got %0d bytes want %0d", outq.size() - base, expq.size());
    end else begin
      for (int i = 0; i < expq.size(); i++) begin
        tests++; if (outq[base+i] !== expq[i]) begin
          fails++; $display("FAIL wait_byte%0d: got %h want %h", i, outq[base+i], expq[i]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int w, base;
    mbits.delete();
    send(27'h5A5A5A5, 27, 1'b0, w);
    send(27'h5A5A5A5, 27, 1'b0, w);
    send(27'h5A5A5A5, 27, 1'b1, w);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    tests++; if ({o_data, o_valid, o_data_end} !== 10'h000) begin
      fails++; $display("FAIL areset_outputs: got d=%h v=%b e=%b want 00 0 0", o_data, o_valid, o_data_end);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    base = outq.size();
    mbits.delete();
    send(27'hA5, 8, 1'b0, w);
    repeat (4) @(posedge clk); #1;
    tests++; if (outq.size() - base != 1) begin
      fails++; $display("FAIL areset_count: got %0d bytes want 1", outq.size() - base);
    end else begin
      tests++; if (outq[base] !== 8'hA5) begin fails++; $display("FAIL areset_byte: got %h want A5", outq[base]); end
    end
    tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL areset_ready: got %b want 1", o_ready); end
  endtask

  initial begin
    rst = 1'b1; i_wait = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_code = '0; i_len = '0;
    test_reset();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    test_pack();
    test_ff_bubble();
    test_flush();
    test_flush_empty();
    test_back_to_back();
    test_wait();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
